// File: rtl/vga_pkg.sv
// Shared types and constants for the two-port VGA RAM arbiter.
// Requester 0 is display refresh and requester 1 is the host.
package vga_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  typedef logic req_id_t;

  localparam req_id_t REQ_DISPLAY = 1'b0;
  localparam req_id_t REQ_HOST    = 1'b1;

  // Identifies the read in flight so its data is flagged to the right requester.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } pend_t;

endpackage

// File: rtl/vga_rr_grant.sv
// Two-way grant: a single requester always wins. On contention, the urgent display wins;
// otherwise the requester that did not win most recently wins.
module vga_rr_grant
  import vga_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    req0,
  input  logic    req1,
  input  logic    urgent0,
  output logic    grant0,
  output logic    grant1,
  output logic    grant_valid,
  output req_id_t grant_id
);

  req_id_t last_grant_q, last_grant_d;

  // NOTE: give every always_comb output a default first, so no path infers a latch.
  always_comb begin
    grant_valid = (req0 | req1) & ~reset;
    grant_id    = REQ_DISPLAY;
    if (req0 && req1) begin
      grant_id = urgent0 ? REQ_DISPLAY : ~last_grant_q;
    end else if (req1) begin
      grant_id = REQ_HOST;
    end
    grant0       = grant_valid & (grant_id == REQ_DISPLAY);
    grant1       = grant_valid & (grant_id == REQ_HOST);
    last_grant_d = grant_valid ? grant_id : last_grant_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= REQ_HOST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/vga_ram_arbiter.sv
// Shares one single-cycle-latency RAM port between display refresh and host.
// Read data goes to both requesters, and only readdatavalid is steered to the issuer.
module vga_ram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   r0_address,
  input  logic [DATA_W/8-1:0] r0_byteenable,
  input  logic                r0_read,
  input  logic                r0_write,
  input  logic [DATA_W-1:0]   r0_writedata,
  input  logic                r0_urgent,
  output logic                r0_waitrequest,
  output logic [DATA_W-1:0]   r0_readdata,
  output logic                r0_readdatavalid,

  input  logic [ADDR_W-1:0]   r1_address,
  input  logic [DATA_W/8-1:0] r1_byteenable,
  input  logic                r1_read,
  input  logic                r1_write,
  input  logic [DATA_W-1:0]   r1_writedata,
  output logic                r1_waitrequest,
  output logic [DATA_W-1:0]   r1_readdata,
  output logic                r1_readdatavalid,

  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  output logic                m_chipselect,
  output logic                m_write,
  input  logic [DATA_W-1:0]   m_readdata
);

  logic    req0, req1;
  logic    grant0, grant1, grant_valid;
  req_id_t grant_id;
  logic    sel_write;
  pend_t   pending_q, pending_d;

  assign req0 = r0_read | r0_write;
  assign req1 = r1_read | r1_write;

  vga_rr_grant u_grant (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .urgent0     (r0_urgent),
    .grant0      (grant0),
    .grant1      (grant1),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Read and write together counts as a write.
  always_comb begin
    sel_write    = 1'b0;
    m_address    = r0_address;
    m_byteenable = r0_byteenable;
    m_writedata  = r0_writedata;
    if (grant_id == REQ_HOST) begin
      sel_write    = r1_write;
      m_address    = r1_address;
      m_byteenable = r1_byteenable;
      m_writedata  = r1_writedata;
    end else begin
      sel_write    = r0_write;
    end
    if (!sel_write) begin
      m_byteenable = '1;
    end
    m_chipselect = grant_valid;
    m_write      = grant_valid & sel_write;
  end

  always_comb begin
    pending_d.valid = grant_valid & ~sel_write;
    pending_d.id    = grant_id;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '{valid: 1'b0, id: REQ_DISPLAY};
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    r0_waitrequest   = req0 & ~grant0;
    r1_waitrequest   = req1 & ~grant1;
    r0_readdata      = m_readdata;
    r1_readdata      = m_readdata;
    r0_readdatavalid = pending_q.valid & (pending_q.id == REQ_DISPLAY);
    r1_readdatavalid = pending_q.valid & (pending_q.id == REQ_HOST);
  end

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Directed bench for vga_ram_arbiter with a behavioural RAM on the m_ port.
// Expected read data is queued when the read is issued and compared one cycle later.
module tb_vga_ram_arbiter;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] r0_address, r1_address;
  logic [3:0]  r0_byteenable, r1_byteenable;
  logic        r0_read, r0_write, r1_read, r1_write, r0_urgent;
  logic [31:0] r0_writedata, r1_writedata;
  logic        r0_waitrequest, r1_waitrequest;
  logic [31:0] r0_readdata, r1_readdata;
  logic        r0_readdatavalid, r1_readdatavalid;
  logic [11:0] m_address;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata, m_readdata;
  logic        m_chipselect, m_write;

  typedef struct {
    req_id_t     id;
    logic [31:0] data;
  } exp_rd_t;

  exp_rd_t     exp_q[$];
  logic [31:0] ref_mem [0:4095];
  logic [31:0] ram     [0:4095];
  logic [11:0] ram_addr_q;
  req_id_t     ref_last;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  vga_ram_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .r0_address       (r0_address),
    .r0_byteenable    (r0_byteenable),
    .r0_read          (r0_read),
    .r0_write         (r0_write),
    .r0_writedata     (r0_writedata),
    .r0_urgent        (r0_urgent),
    .r0_waitrequest   (r0_waitrequest),
    .r0_readdata      (r0_readdata),
    .r0_readdatavalid (r0_readdatavalid),
    .r1_address       (r1_address),
    .r1_byteenable    (r1_byteenable),
    .r1_read          (r1_read),
    .r1_write         (r1_write),
    .r1_writedata     (r1_writedata),
    .r1_waitrequest   (r1_waitrequest),
    .r1_readdata      (r1_readdata),
    .r1_readdatavalid (r1_readdatavalid),
    .m_address        (m_address),
    .m_byteenable     (m_byteenable),
    .m_writedata      (m_writedata),
    .m_chipselect     (m_chipselect),
    .m_write          (m_write),
    .m_readdata       (m_readdata)
  );

  function automatic logic [31:0] pattern(input logic [11:0] a);
    return {20'hC0DE0, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
    end
    return w;
  endfunction

  // RAM: address registered on chipselect, read data combinational from that register.
  initial begin
    logic [31:0] w;
    for (int i = 0; i < 4096; i++) ram[i] = pattern(12'(i));
    ram[12'h010] = 32'hDEADBEEF;
    ram[12'h123] = 32'h11223344;
    ram_addr_q   = '0;
    forever begin
      @(posedge clk);
      if (m_chipselect) begin
        if (m_write) begin
          w = merge(ram[m_address], m_writedata, m_byteenable);
          ram[m_address] <= w;
        end
        ram_addr_q <= m_address;
      end
    end
  end

  assign m_readdata = ram[ram_addr_q];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks one cycle against the reference arbiter and then advances past the next edge.
  task automatic run_cycle(input string tag);
    exp_rd_t     e;
    logic        q0, q1, g_any, wr;
    req_id_t     g;
    logic [11:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    @(negedge clk);
    q0 = r0_read | r0_write;
    q1 = r1_read | r1_write;
    if (reset) begin
      check({tag, ".wait0"}, 32'(r0_waitrequest), 32'(q0));
      check({tag, ".wait1"}, 32'(r1_waitrequest), 32'(q1));
      check({tag, ".cs"},    32'(m_chipselect), 32'd0);
      check({tag, ".rdv0"},  32'(r0_readdatavalid), 32'd0);
      check({tag, ".rdv1"},  32'(r1_readdatavalid), 32'd0);
      exp_q.delete();
      ref_last = REQ_HOST;
    end else begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({tag, ".rdv0"}, 32'(r0_readdatavalid), 32'(e.id == REQ_DISPLAY));
        check({tag, ".rdv1"}, 32'(r1_readdatavalid), 32'(e.id == REQ_HOST));
        check({tag, ".rdata"}, (e.id == REQ_HOST) ? r1_readdata : r0_readdata, e.data);
      end else begin
        check({tag, ".rdv0_idle"}, 32'(r0_readdatavalid), 32'd0);
        check({tag, ".rdv1_idle"}, 32'(r1_readdatavalid), 32'd0);
      end
      g_any = q0 | q1;
      if (q0 && q1) g = r0_urgent ? REQ_DISPLAY : ((ref_last == REQ_DISPLAY) ? REQ_HOST : REQ_DISPLAY);
      else          g = q1 ? REQ_HOST : REQ_DISPLAY;
      check({tag, ".wait0"}, 32'(r0_waitrequest), 32'(q0 & ~(g_any & (g == REQ_DISPLAY))));
      check({tag, ".wait1"}, 32'(r1_waitrequest), 32'(q1 & ~(g_any & (g == REQ_HOST))));
      check({tag, ".cs"},    32'(m_chipselect), 32'(g_any));
      if (g_any) begin
        wr = (g == REQ_HOST) ? r1_write      : r0_write;
        a  = (g == REQ_HOST) ? r1_address    : r0_address;
        be = (g == REQ_HOST) ? r1_byteenable : r0_byteenable;
        wd = (g == REQ_HOST) ? r1_writedata  : r0_writedata;
        check({tag, ".mwr"},  32'(m_write), 32'(wr));
        check({tag, ".maddr"}, 32'(m_address), 32'(a));
        if (wr) begin
          check({tag, ".mbe"}, 32'(m_byteenable), 32'(be));
          check({tag, ".mwd"}, m_writedata, wd);
          ref_mem[a] = merge(ref_mem[a], wd, be);
        end else begin
          check({tag, ".mbe_rd"}, 32'(m_byteenable), 32'hF);
          exp_q.push_back('{id: g, data: ref_mem[a]});
        end
        ref_last = g;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run_cycle("rst");
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = pattern(12'(i));
    ref_mem[12'h010] = 32'hDEADBEEF;
    ref_mem[12'h123] = 32'h11223344;
    ref_last      = REQ_HOST;
    reset         = 1'b1;
    r0_address    = '0; r0_byteenable = '0; r0_read = 1'b0; r0_write = 1'b0;
    r0_writedata  = '0; r0_urgent = 1'b0;
    r1_address    = '0; r1_byteenable = '0; r1_read = 1'b0; r1_write = 1'b0;
    r1_writedata  = '0;
    @(posedge clk);
    #1;
    r1_read = 1'b1; r1_address = 12'h005;
    run_cycle("rst_follow");
    r1_read = 1'b0;
    reset = 1'b0;

    // Scenario 1: display read alone.
    r0_read = 1'b1; r0_address = 12'h010;
    run_cycle("s1_issue");
    r0_read = 1'b0;
    check("s1.rdv0", 32'(r0_readdatavalid), 32'd1);
    check("s1.rdata0", r0_readdata, 32'hDEADBEEF);
    check("s1.rdv1", 32'(r1_readdatavalid), 32'd0);
    run_cycle("s1_data");

    // Scenario 2: continuous contention after reset alternates r0, r1, ...
    do_reset();
    r0_read = 1'b1; r1_read = 1'b1;
    for (int i = 0; i < 6; i++) begin
      r0_address = 12'(12'h020 + i);
      r1_address = 12'(12'h040 + i);
      run_cycle($sformatf("s2_%0d", i));
    end
    r0_read = 1'b0; r1_read = 1'b0;
    run_cycle("s2_drain");

    // Scenario 3: partial host write then read-after-write on the next cycle.
    r1_write = 1'b1; r1_address = 12'h123; r1_byteenable = 4'h3; r1_writedata = 32'hAABBCCDD;
    run_cycle("s3_wr");
    r1_write = 1'b0; r1_read = 1'b1;
    run_cycle("s3_rd");
    r1_read = 1'b0;
    check("s3.rdv1", 32'(r1_readdatavalid), 32'd1);
    check("s3.rdata1", r1_readdata, 32'h1122CCDD);
    run_cycle("s3_data");

    // Scenario 4: urgent display holds off the host, which then wins once urgency drops.
    r0_read = 1'b1; r1_read = 1'b1; r0_address = 12'h060; r1_address = 12'h070;
    r0_urgent = 1'b1;
    for (int i = 0; i < 4; i++) run_cycle($sformatf("s4_urg%0d", i));
    r0_urgent = 1'b0;
    run_cycle("s4_release");
    r0_read = 1'b0; r1_read = 1'b0;
    run_cycle("s4_drain");

    // Scenario 5: reset lands on a display read, with a host read still in flight.
    r1_read = 1'b1; r1_address = 12'h080;
    run_cycle("s5_pre");
    r1_read = 1'b0; r0_read = 1'b1; r0_address = 12'h090;
    reset = 1'b1;
    run_cycle("s5_rst");
    reset = 1'b0; r0_read = 1'b0;
    run_cycle("s5_after");
    r0_read = 1'b1; r1_read = 1'b1;
    run_cycle("s5_contend");
    r0_read = 1'b0; r1_read = 1'b0;
    run_cycle("s5_drain");

    // Scenario 6: three back-to-back host writes; the middle one also asserts read.
    r1_write = 1'b1; r1_byteenable = 4'hF;
    for (int i = 0; i < 3; i++) begin
      r1_address   = 12'(12'h200 + i);
      r1_writedata = 32'h5A5A0000 + 32'(i);
      r1_read      = (i == 1);
      run_cycle($sformatf("s6_wr%0d", i));
    end
    r1_write = 1'b0; r1_read = 1'b0;
    r0_write = 1'b1; r0_address = 12'h201; r0_byteenable = 4'h8; r0_writedata = 32'h77000000;
    run_cycle("s6_r0wr");
    r0_write = 1'b0; r0_read = 1'b1;
    run_cycle("s6_r0rd");
    r0_read = 1'b0;
    check("s6.rdata0", r0_readdata, 32'h775A0001);
    run_cycle("s6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
